// File: rtl/objects_mux_hit_pkg.sv
// Shared constants and enums for the object compositor and its collision detectors.
package objects_mux_hit_pkg;

    localparam logic [7:0] TRANSPARENT_ENCODING = 8'h00;
    localparam int         NUM_HITS             = 4;

    typedef enum logic {
        ARMED = 1'b0,
        FIRED = 1'b1
    } hit_state_e;

    typedef enum logic [1:0] {
        PLAYER   = 2'd0,
        ALIEN    = 2'd1,
        SHIELD_P = 2'd2,
        SHIELD_A = 2'd3
    } hit_idx_e;

endpackage

// File: rtl/objects_mux_hit_pulse_gen.sv
// One collision detector: fires a single registered pulse per frame on its condition.
module hit_pulse_gen
    import objects_mux_hit_pkg::*;
(
    input  logic clk,
    input  logic resetN,
    input  logic start_of_frame,
    input  logic play_game,
    input  logic cond,
    output logic pulse
);

    hit_state_e state_q, state_d, state_eff;
    logic       pulse_q, pulse_d;

    always_comb begin
        state_d   = state_q;
        pulse_d   = 1'b0;
        // A frame boundary re-arms before the condition is looked at, so a
        // same-cycle collision belongs to the new frame.
        state_eff = start_of_frame ? ARMED : state_q;
        if (!play_game) begin
            state_d = ARMED;
        end else if (state_eff == ARMED && cond) begin
            state_d = FIRED;
            pulse_d = 1'b1;
        end else begin
            state_d = state_eff;
        end
    end

    always_ff @(posedge clk or negedge resetN) begin
        if (!resetN) begin
            state_q <= ARMED;
            pulse_q <= 1'b0;
        end else begin
            state_q <= state_d;
            pulse_q <= pulse_d;
        end
    end

    assign pulse = pulse_q;

endmodule

// File: rtl/objects_mux_hit.sv
// Pixel compositor with fixed object priority plus per-frame collision pulses and a hit counter.
module objects_mux_hit
    import objects_mux_hit_pkg::*;
#(
    parameter logic [7:0] TRANSPARENT_ENCODING = objects_mux_hit_pkg::TRANSPARENT_ENCODING,
    parameter int         HIT_COUNT_MAX        = 15
) (
    input  logic       clk,
    input  logic       resetN,
    input  logic       startOfFrame,
    input  logic       playGame,
    input  logic       playerDR,
    input  logic [7:0] playerRGB,
    input  logic       alienDR,
    input  logic [7:0] alienRGB,
    input  logic       playerShotDR,
    input  logic [7:0] playerShotRGB,
    input  logic       alienShotDR,
    input  logic [7:0] alienShotRGB,
    input  logic       shieldDR,
    input  logic [7:0] shieldRGB,
    input  logic [7:0] backgroundRGB,
    output logic [7:0] RGBOut,
    output logic       playerHit,
    output logic       alienHit,
    output logic       shieldHitByPlayerShot,
    output logic       shieldHitByAlienShot,
    output logic [3:0] playerHitCount
);

    localparam logic [3:0] CNT_MAX = 4'(HIT_COUNT_MAX);

    // Priority is decided by drawing requests alone; the transparent colour
    // is kept only as a documented parameter.
    logic unused_transparent;
    assign unused_transparent = ^TRANSPARENT_ENCODING;

    logic [7:0] rgb_q, rgb_d;
    logic [3:0] cnt_q, cnt_d;
    logic [NUM_HITS-1:0] hit_cond, hit_pulse;

    always_comb begin
        rgb_d = backgroundRGB;
        if      (playerShotDR) rgb_d = playerShotRGB;
        else if (alienShotDR)  rgb_d = alienShotRGB;
        else if (alienDR)      rgb_d = alienRGB;
        else if (playerDR)     rgb_d = playerRGB;
        else if (shieldDR)     rgb_d = shieldRGB;
    end

    always_comb begin
        hit_cond           = '0;
        hit_cond[PLAYER]   = playerDR && alienShotDR;
        hit_cond[ALIEN]    = alienDR  && playerShotDR;
        hit_cond[SHIELD_P] = shieldDR && playerShotDR;
        hit_cond[SHIELD_A] = shieldDR && alienShotDR;
    end

    for (genvar i = 0; i < NUM_HITS; i++) begin : g_hit
        hit_pulse_gen u_hit (
            .clk            (clk),
            .resetN         (resetN),
            .start_of_frame (startOfFrame),
            .play_game      (playGame),
            .cond           (hit_cond[i]),
            .pulse          (hit_pulse[i])
        );
    end

    // Counts the registered pulse, so the count moves the cycle after playerHit.
    always_comb begin
        cnt_d = cnt_q;
        if (!playGame)
            cnt_d = '0;
        else if (hit_pulse[PLAYER] && cnt_q != CNT_MAX)
            cnt_d = cnt_q + 4'd1;
    end

    always_ff @(posedge clk or negedge resetN) begin
        if (!resetN) begin
            rgb_q <= 8'h00;
            cnt_q <= '0;
        end else begin
            rgb_q <= rgb_d;
            cnt_q <= cnt_d;
        end
    end

    assign RGBOut                = rgb_q;
    assign playerHitCount        = cnt_q;
    assign playerHit             = hit_pulse[PLAYER];
    assign alienHit              = hit_pulse[ALIEN];
    assign shieldHitByPlayerShot = hit_pulse[SHIELD_P];
    assign shieldHitByAlienShot  = hit_pulse[SHIELD_A];

endmodule
